// File: rtl/timer_irq_latency_monitor.sv
// Measures timer irq service latency (cycles irq stays high) and keeps count/last/max/min for readback.
// readdata is registered (one-cycle lag behind address); no backpressure, writes take effect at the next edge.
module timer_irq_latency_monitor #(
    parameter int LAT_W = 16,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq_in,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        active
);

    typedef enum logic {IDLE, MEASURE} state_t;

    localparam logic [LAT_W-1:0] LAT_MAX = {LAT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q;
    logic               irq_d_q;
    logic [LAT_W-1:0]   lat_cnt_q;
    logic [LAT_W-1:0]   last_q;
    logic [LAT_W-1:0]   max_q;
    logic [LAT_W-1:0]   min_q;
    logic [CNT_W-1:0]   event_count_q;
    logic               enable_q;
    logic               lat_sat_q;
    logic               cnt_ovf_q;
    logic [15:0]        readdata_q;
    logic [15:0]        readdata_d;

    logic wr, ctrl_wr, stat_wr, clr, abort, rise, fall;
    logic unused_wdata;

    assign wr      = chipselect & ~write_n;
    assign ctrl_wr = wr & (address == 3'd1);
    assign stat_wr = wr & (address == 3'd0);
    assign clr     = ctrl_wr & writedata[1];
    assign abort   = ctrl_wr & ~writedata[0];
    assign rise    = irq_in & ~irq_d_q;
    assign fall    = ~irq_in & irq_d_q;

    assign unused_wdata = ^writedata[15:2];

    assign active   = (state_q == MEASURE);
    assign readdata = readdata_q;

    always_comb begin
        readdata_d = '0;
        case (address)
            3'd0:    readdata_d = {13'b0, lat_sat_q, cnt_ovf_q, active};
            3'd1:    readdata_d = {15'b0, enable_q};
            3'd2:    readdata_d = 16'(event_count_q);
            3'd3:    readdata_d = 16'(last_q);
            3'd4:    readdata_d = 16'(max_q);
            3'd5:    readdata_d = 16'(min_q);
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            irq_d_q       <= 1'b0;
            lat_cnt_q     <= '0;
            last_q        <= '0;
            max_q         <= '0;
            min_q         <= LAT_MAX;
            event_count_q <= '0;
            enable_q      <= 1'b0;
            lat_sat_q     <= 1'b0;
            cnt_ovf_q     <= 1'b0;
            readdata_q    <= '0;
        end else begin
            irq_d_q    <= irq_in;
            readdata_q <= readdata_d;

            // Flag clears come first so a flag event in the same cycle still wins.
            if (stat_wr) begin
                lat_sat_q <= 1'b0;
                cnt_ovf_q <= 1'b0;
            end
            if (ctrl_wr) begin
                enable_q <= writedata[0];
            end

            if (clr) begin
                event_count_q <= '0;
                last_q        <= '0;
                max_q         <= '0;
                min_q         <= LAT_MAX;
                state_q       <= IDLE;
            end else if (abort) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise && enable_q) begin
                            state_q       <= MEASURE;
                            lat_cnt_q     <= LAT_W'(1);
                            event_count_q <= event_count_q + CNT_W'(1);
                            if (event_count_q == CNT_MAX) begin
                                cnt_ovf_q <= 1'b1;
                            end
                        end
                    end
                    MEASURE: begin
                        if (fall) begin
                            state_q <= IDLE;
                            last_q  <= lat_cnt_q;
                            if (lat_cnt_q > max_q) max_q <= lat_cnt_q;
                            if (lat_cnt_q < min_q) min_q <= lat_cnt_q;
                        end else if (irq_in) begin
                            if (lat_cnt_q == LAT_MAX) begin
                                lat_sat_q <= 1'b1;
                            end else begin
                                lat_cnt_q <= lat_cnt_q + LAT_W'(1);
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_irq_latency_monitor.sv
// Drives three monitor instances (default, LAT_W=4, CNT_W=2) with shared stimulus and
// compares every register against a pulse-level model of the measurement rules.
module tb_timer_irq_latency_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        irq_in;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] rd0, rd1, rd2;
    logic        act0, act1, act2;

    always #5 clk = ~clk;

    timer_irq_latency_monitor #(.LAT_W(16), .CNT_W(16)) dut_base (
        .clk(clk), .reset(reset), .irq_in(irq_in), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(rd0), .active(act0));

    timer_irq_latency_monitor #(.LAT_W(4), .CNT_W(16)) dut_lat4 (
        .clk(clk), .reset(reset), .irq_in(irq_in), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(rd1), .active(act1));

    timer_irq_latency_monitor #(.LAT_W(16), .CNT_W(2)) dut_cnt2 (
        .clk(clk), .reset(reset), .irq_in(irq_in), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(rd2), .active(act2));

    int checks   = 0;
    int failures = 0;

    int lw [3] = '{16, 4, 16};
    int cw [3] = '{16, 16, 2};
    int m_ev [3], m_last [3], m_max [3], m_min [3];
    bit m_sat [3], m_ovf [3];
    bit m_en;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rd_of(input int i);
        return (i == 0) ? rd0 : (i == 1) ? rd1 : rd2;
    endfunction

    function automatic logic act_of(input int i);
        return (i == 0) ? act0 : (i == 1) ? act1 : act2;
    endfunction

    function automatic int lmax(input int i);
        return (1 << lw[i]) - 1;
    endfunction

    function automatic void m_reset();
        m_en = 0;
        for (int i = 0; i < 3; i++) begin
            m_ev[i] = 0; m_last[i] = 0; m_max[i] = 0; m_min[i] = lmax(i);
            m_sat[i] = 0; m_ovf[i] = 0;
        end
    endfunction

    function automatic void m_count_event();
        for (int i = 0; i < 3; i++) begin
            m_ev[i] = (m_ev[i] + 1) % (1 << cw[i]);
            if (m_ev[i] == 0) m_ovf[i] = 1;
        end
    endfunction

    // A measurement that saw n high samples saturates once n exceeds the counter range.
    function automatic void m_sat_only(input int n);
        for (int i = 0; i < 3; i++) if (n > lmax(i)) m_sat[i] = 1;
    endfunction

    function automatic void m_capture(input int n);
        m_sat_only(n);
        for (int i = 0; i < 3; i++) begin
            int lat;
            lat = (n > lmax(i)) ? lmax(i) : n;
            m_last[i] = lat;
            if (lat > m_max[i]) m_max[i] = lat;
            if (lat < m_min[i]) m_min[i] = lat;
        end
    endfunction

    function automatic int exp_reg(input int i, input int a);
        case (a)
            0: return (int'(m_sat[i]) << 2) | (int'(m_ovf[i]) << 1);
            1: return int'(m_en);
            2: return m_ev[i];
            3: return m_last[i];
            4: return m_max[i];
            5: return m_min[i];
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [15:0] data);
        chipselect = 1'b1; write_n = 1'b0; address = addr; writedata = data;
        tick();
        chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;
        if (addr == 3'd0) begin
            for (int i = 0; i < 3; i++) begin m_sat[i] = 0; m_ovf[i] = 0; end
        end
        if (addr == 3'd1) begin
            if (data[1]) begin
                for (int i = 0; i < 3; i++) begin
                    m_ev[i] = 0; m_last[i] = 0; m_max[i] = 0; m_min[i] = lmax(i);
                end
            end
            m_en = data[0];
        end
    endtask

    task automatic ctrl(input bit clr, input bit en);
        bus_write(3'd1, {14'b0, clr, en});
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            tick();
            for (int i = 0; i < 3; i++)
                chk($sformatf("%s_inst%0d_addr%0d", tag, i, a), 32'(rd_of(i)), 32'(exp_reg(i, a)));
        end
        address = 3'd0;
    endtask

    task automatic check_active(input string tag, input bit exp);
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s_active_inst%0d", tag, i), 32'(act_of(i)), 32'(exp));
    endtask

    task automatic pulse(input int len);
        bit counted;
        counted = m_en;
        irq_in = 1'b1;
        tick();
        if (counted) m_count_event();
        check_active("pulse_mid", counted);
        repeat (len - 1) tick();
        irq_in = 1'b0;
        tick();
        tick();
        if (counted) m_capture(len);
        check_active("pulse_end", 1'b0);
    endtask

    task automatic abort_pulse(input int len, input int k);
        bit counted;
        counted = m_en;
        irq_in = 1'b1;
        tick();
        if (counted) m_count_event();
        repeat (k - 1) tick();
        ctrl(1'b0, 1'b0);
        if (counted) m_sat_only(k);
        check_active("abort", 1'b0);
        repeat (len - k - 1) tick();
        irq_in = 1'b0;
        tick();
        tick();
    endtask

    task automatic clear_on_fall(input int len, input bit en);
        bit counted;
        counted = m_en;
        irq_in = 1'b1;
        tick();
        if (counted) m_count_event();
        repeat (len - 1) tick();
        irq_in = 1'b0;
        if (counted) m_sat_only(len);
        ctrl(1'b1, en);
        tick();
        check_active("clrfall", 1'b0);
    endtask

    initial begin
        reset = 1'b1; irq_in = 1'b0; address = 3'd0;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        tick();
        tick();
        reset = 1'b0;
        m_reset();
        check_active("reset", 1'b0);
        read_all("reset");

        ctrl(1'b0, 1'b1);
        pulse(37);
        read_all("single37");

        ctrl(1'b1, 1'b1);
        pulse(20); pulse(50); pulse(10);
        read_all("three_pulses");

        ctrl(1'b1, 1'b1);
        abort_pulse(30, 5);
        read_all("abort");

        ctrl(1'b0, 1'b0);
        pulse(8);
        read_all("disabled_rise");

        ctrl(1'b1, 1'b1);
        pulse(20);
        read_all("lat_sat");
        bus_write(3'd0, 16'h0000);
        read_all("flag_clear");

        pulse(12);
        clear_on_fall(9, 1'b1);
        read_all("clear_fall");

        ctrl(1'b1, 1'b1);
        repeat (4) pulse(3);
        read_all("cnt_wrap");

        // Reset in the middle of a measurement: the later fall must not capture.
        irq_in = 1'b1;
        tick();
        m_count_event();
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_reset();
        repeat (5) tick();
        irq_in = 1'b0;
        tick();
        tick();
        read_all("reset_mid");

        ctrl(1'b0, 1'b1);
        for (int n = 0; n < 60; n++) begin
            int op, len;
            op  = int'($urandom_range(0, 6));
            len = int'($urandom_range(1, 40));
            case (op)
                0, 1: pulse(len);
                2: begin
                    len = int'($urandom_range(4, 40));
                    abort_pulse(len, int'($urandom_range(1, len - 2)));
                end
                3: ctrl($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
                4: bus_write(3'd0, 16'($urandom()));
                5: clear_on_fall(len, $urandom_range(0, 1) == 1);
                default: ctrl(1'b0, 1'b1);
            endcase
            read_all($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
